// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC cascade logic.
package pic_pkg;

   localparam int CAS_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      GAP1 = 2'd2,
      ACK2 = 2'd3
   } inta_state_t;

   localparam logic [1:0] INTA_PHASE_IDLE   = 2'd0;
   localparam logic [1:0] INTA_PHASE_FIRST  = 2'd1;
   localparam logic [1:0] INTA_PHASE_SECOND = 2'd2;

endpackage

// File: rtl/inta_edge_det.sv
// Registered edge detector for an active-low strobe: one-cycle fall and rise pulses
// derived from a registered copy of the signal.
module inta_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_n,
   output logic fall,
   output logic rise
);

   logic sig_q;

   // Idle level of an active-low strobe is high, so reset the copy high to avoid a false fall.
   always_ff @(posedge clk) begin
      if (!rst_n) sig_q <= 1'b1;
      else        sig_q <= sig_n;
   end

   assign fall = sig_q & ~sig_n;
   assign rise = ~sig_q & sig_n;

endmodule

// File: rtl/cascade_ctrl.sv
// Clocked PIC cascade controller: ICW3 register, INTA sequence FSM, CAS bus drive and
// vector-drive grant. Optional buffered-mode master select is enabled by defining BUF_MODE_EN.
module cascade_ctrl
   import pic_pkg::*;
#(
   parameter int CAS_W  = CAS_W_DEF,
   parameter int NUM_IR = 2**CAS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icw3_wr,
   input  logic [NUM_IR-1:0] icw3_data,
   input  logic              sngl,
   input  logic              sp_en_n,
   input  logic              inta_n,
   input  logic [CAS_W-1:0]  ack_ir,
   input  logic              ack_valid,
   input  logic [CAS_W-1:0]  cas_i,
`ifdef BUF_MODE_EN
   input  logic              buf_mode,
   input  logic              buf_ms,
   output logic              en_n,
`endif
   output logic [CAS_W-1:0]  cas_o,
   output logic              cas_oe,
   output logic              is_master,
   output logic [CAS_W-1:0]  slave_id,
   output logic              vec_drv,
   output logic [1:0]        inta_phase
);

   inta_state_t       state_reg, state_next;
   logic [NUM_IR-1:0] icw3_reg;
   logic [CAS_W-1:0]  ir_q;
   logic [CAS_W-1:0]  seq_id_reg;
   logic              slv_hit_reg;
   logic              valid_reg;
   logic              match_reg;
   logic              seq_master_reg;
   logic              seq_sngl_reg;
   logic              is_master_reg;
   logic              master_sel;
   logic              inta_fall;
   logic              inta_rise;

   inta_edge_det u_inta_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_n (inta_n),
      .fall  (inta_fall),
      .rise  (inta_rise)
   );

`ifdef BUF_MODE_EN
   assign master_sel = buf_mode ? buf_ms : sp_en_n;
`else
   assign master_sel = sp_en_n;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (inta_fall) state_next = ACK1;
         ACK1:    if (inta_rise) state_next = GAP1;
         GAP1:    if (inta_fall) state_next = ACK2;
         ACK2:    if (inta_rise) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Mode, IR, hit and ID are frozen at the first fall so mid-sequence config changes wait for IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         icw3_reg       <= '0;
         ir_q           <= '0;
         seq_id_reg     <= '0;
         slv_hit_reg    <= 1'b0;
         valid_reg      <= 1'b0;
         match_reg      <= 1'b0;
         seq_master_reg <= 1'b0;
         seq_sngl_reg   <= 1'b0;
         is_master_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         is_master_reg <= sngl | master_sel;
         if (icw3_wr) icw3_reg <= icw3_data;
         if (state_reg == IDLE && inta_fall) begin
            ir_q           <= ack_ir;
            slv_hit_reg    <= icw3_reg[ack_ir] & ack_valid;
            valid_reg      <= ack_valid;
            seq_id_reg     <= icw3_reg[CAS_W-1:0];
            seq_master_reg <= sngl | master_sel;
            seq_sngl_reg   <= sngl;
            match_reg      <= 1'b0;
         end
         if (state_reg == GAP1 && inta_fall)
            match_reg <= (cas_i == seq_id_reg);
      end
   end

   always_comb begin
      cas_oe = (state_reg != IDLE) & seq_master_reg & ~seq_sngl_reg & slv_hit_reg;
      cas_o  = cas_oe ? ir_q : '0;
      vec_drv = 1'b0;
      if (state_reg == ACK2 && valid_reg) begin
         if (seq_sngl_reg)        vec_drv = 1'b1;
         else if (seq_master_reg) vec_drv = ~slv_hit_reg;
         else                     vec_drv = match_reg;
      end
      case (state_reg)
         ACK1:    inta_phase = INTA_PHASE_FIRST;
         ACK2:    inta_phase = INTA_PHASE_SECOND;
         default: inta_phase = INTA_PHASE_IDLE;
      endcase
   end

   assign is_master = is_master_reg;
   assign slave_id  = icw3_reg[CAS_W-1:0];

`ifdef BUF_MODE_EN
   assign en_n = ~(cas_oe | vec_drv);
`endif

endmodule
